// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_if
// Description : ID-stage instruction, datapath status and pipeline control
//               bundle between the RV32I datapath and its hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_controller_if #(
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   pipe_en;
    logic [6:0]             inst_control;
    logic [9:0]             inst_alu;
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic [REG_AW-1:0]      id_rd;
    logic                   zero_flag;
    logic                   mem_ready;

    logic [3:0]             ex_alu_op;
    logic                   ex_alu_src;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;
    logic                   m_memw;
    logic                   m_memr;
    logic                   wb_regw;
    logic                   wb_mem2reg;
    logic                   sel;
    logic                   stall;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_count;

    // Datapath side: supplies instruction/status, consumes controls.
    modport master (
        output pipe_en, inst_control, inst_alu, id_rs1, id_rs2, id_rd,
               zero_flag, mem_ready,
        input  ex_alu_op, ex_alu_src, fwd_a, fwd_b, m_memw, m_memr,
               wb_regw, wb_mem2reg, sel, stall, flush, stall_count
    );

    // Controller side.
    modport slave (
        input  pipe_en, inst_control, inst_alu, id_rs1, id_rs2, id_rd,
               zero_flag, mem_ready,
        output ex_alu_op, ex_alu_src, fwd_a, fwd_b, m_memw, m_memr,
               wb_regw, wb_mem2reg, sel, stall, flush, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : 5-stage RV32I control unit: decode, ID/EX/M/WB control
//               pipeline, load-use stall, forwarding, branch flush, LSU freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int REG_AW      = 5,
    parameter bit FWD_EN      = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    pipeline_hazard_controller_if.slave bus
);
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_XOR = 4'b0011;

    localparam logic [1:0] c_FWD_RF = 2'b00;
    localparam logic [1:0] c_FWD_M  = 2'b10;
    localparam logic [1:0] c_FWD_WB = 2'b01;

    typedef struct packed {
        logic [3:0]        alu_op;
        logic              alu_src;
        logic              memr;
        logic              memw;
        logic              regw;
        logic              mem2reg;
        logic              branch;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } idex_t;

    typedef struct packed {
        logic              memr;
        logic              memw;
        logic              regw;
        logic              mem2reg;
        logic [REG_AW-1:0] rd;
    } exm_t;

    typedef struct packed {
        logic              regw;
        logic              mem2reg;
        logic [REG_AW-1:0] rd;
    } mwb_t;

    idex_t                  r_idex_q, w_idex_d, w_id_dec;
    exm_t                   r_exm_q,  w_exm_d;
    mwb_t                   r_mwb_q,  w_mwb_d;
    logic [STALL_CNT_W-1:0] r_stall_cnt_q, w_stall_cnt_d;

    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic [3:0] w_alu_func;
    logic [3:0] w_alu_rtype;
    logic       w_id_rs2_used;

    assign w_funct7 = bus.inst_alu[9:3];
    assign w_funct3 = bus.inst_alu[2:0];

    always_comb begin
        w_alu_func = c_ALU_ADD;
        case (w_funct3)
            3'b111:  w_alu_func = c_ALU_AND;
            3'b110:  w_alu_func = c_ALU_OR;
            3'b100:  w_alu_func = c_ALU_XOR;
            default: w_alu_func = c_ALU_ADD;
        endcase
    end

    // Only funct7=0 (base ops) and 0100000/000 (SUB) are known R-type forms.
    always_comb begin
        w_alu_rtype = c_ALU_ADD;
        if (w_funct7 == 7'b0100000) begin
            w_alu_rtype = (w_funct3 == 3'b000) ? c_ALU_SUB : c_ALU_ADD;
        end else if (w_funct7 == 7'b0000000) begin
            w_alu_rtype = w_alu_func;
        end
    end

    always_comb begin
        w_id_dec      = '0;
        w_id_rs2_used = 1'b0;
        w_id_dec.rd   = bus.id_rd;
        w_id_dec.rs1  = bus.id_rs1;
        w_id_dec.rs2  = bus.id_rs2;
        case (bus.inst_control)
            c_OP_RTYPE: begin
                w_id_dec.regw   = 1'b1;
                w_id_dec.alu_op = w_alu_rtype;
                w_id_rs2_used   = 1'b1;
            end
            c_OP_IALU: begin
                w_id_dec.regw    = 1'b1;
                w_id_dec.alu_src = 1'b1;
                w_id_dec.alu_op  = w_alu_func;
            end
            c_OP_LOAD: begin
                w_id_dec.memr    = 1'b1;
                w_id_dec.regw    = 1'b1;
                w_id_dec.mem2reg = 1'b1;
                w_id_dec.alu_src = 1'b1;
                w_id_dec.alu_op  = c_ALU_ADD;
            end
            c_OP_STORE: begin
                w_id_dec.memw    = 1'b1;
                w_id_dec.alu_src = 1'b1;
                w_id_dec.alu_op  = c_ALU_ADD;
                w_id_rs2_used    = 1'b1;
            end
            c_OP_BRANCH: begin
                w_id_dec.branch = 1'b1;
                w_id_dec.alu_op = c_ALU_SUB;
                w_id_rs2_used   = 1'b1;
            end
            default: begin
                w_id_dec = '0;
            end
        endcase
    end

    logic w_ex_rd_nz, w_m_rd_nz, w_ex_match, w_m_match;
    logic w_load_use, w_raw_stall, w_hazard;
    logic w_freeze, w_sel, w_stall, w_flush;

    assign w_ex_rd_nz = (r_idex_q.rd != '0);
    assign w_m_rd_nz  = (r_exm_q.rd != '0);
    assign w_ex_match = (r_idex_q.rd == bus.id_rs1) |
                        (w_id_rs2_used & (r_idex_q.rd == bus.id_rs2));
    assign w_m_match  = (r_exm_q.rd == bus.id_rs1) |
                        (w_id_rs2_used & (r_exm_q.rd == bus.id_rs2));

    assign w_load_use  = r_idex_q.memr & w_ex_rd_nz & w_ex_match;
    assign w_raw_stall = (r_idex_q.regw & w_ex_rd_nz & w_ex_match) |
                         (r_exm_q.regw  & w_m_rd_nz  & w_m_match);

    generate
        if (FWD_EN) begin : g_fwd
            assign w_hazard = w_load_use;

            always_comb begin
                bus.fwd_a = c_FWD_RF;
                bus.fwd_b = c_FWD_RF;
                if (r_exm_q.regw & w_m_rd_nz & (r_exm_q.rd == r_idex_q.rs1)) begin
                    bus.fwd_a = c_FWD_M;
                end else if (r_mwb_q.regw & (r_mwb_q.rd != '0) &
                             (r_mwb_q.rd == r_idex_q.rs1)) begin
                    bus.fwd_a = c_FWD_WB;
                end
                if (r_exm_q.regw & w_m_rd_nz & (r_exm_q.rd == r_idex_q.rs2)) begin
                    bus.fwd_b = c_FWD_M;
                end else if (r_mwb_q.regw & (r_mwb_q.rd != '0) &
                             (r_mwb_q.rd == r_idex_q.rs2)) begin
                    bus.fwd_b = c_FWD_WB;
                end
            end
        end else begin : g_no_fwd
            // Register file writes before it reads, so WB needs no stall.
            assign w_hazard  = w_load_use | w_raw_stall;
            assign bus.fwd_a = c_FWD_RF;
            assign bus.fwd_b = c_FWD_RF;
        end
    endgenerate

    // Combinational controls are held low while reset is applied.
    assign w_freeze = ~bus.pipe_en | ((r_exm_q.memr | r_exm_q.memw) & ~bus.mem_ready);
    assign w_sel    = ~rst & r_idex_q.branch & bus.zero_flag & ~w_freeze;
    assign w_flush  = w_sel;
    assign w_stall  = ~rst & (w_freeze | (w_hazard & ~w_sel));

    always_comb begin
        w_idex_d      = r_idex_q;
        w_exm_d       = r_exm_q;
        w_mwb_d       = r_mwb_q;
        w_stall_cnt_d = r_stall_cnt_q;
        if (!w_freeze) begin
            w_idex_d         = (w_sel | w_hazard) ? idex_t'('0) : w_id_dec;
            w_exm_d.memr     = r_idex_q.memr;
            w_exm_d.memw     = r_idex_q.memw;
            w_exm_d.regw     = r_idex_q.regw;
            w_exm_d.mem2reg  = r_idex_q.mem2reg;
            w_exm_d.rd       = r_idex_q.rd;
            w_mwb_d.regw     = r_exm_q.regw;
            w_mwb_d.mem2reg  = r_exm_q.mem2reg;
            w_mwb_d.rd       = r_exm_q.rd;
        end
        if (w_stall && !(&r_stall_cnt_q)) begin
            w_stall_cnt_d = r_stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex_q      <= '0;
            r_exm_q       <= '0;
            r_mwb_q       <= '0;
            r_stall_cnt_q <= '0;
        end else begin
            r_idex_q      <= w_idex_d;
            r_exm_q       <= w_exm_d;
            r_mwb_q       <= w_mwb_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign bus.ex_alu_op   = r_idex_q.alu_op;
    assign bus.ex_alu_src  = r_idex_q.alu_src;
    assign bus.m_memw      = r_exm_q.memw;
    assign bus.m_memr      = r_exm_q.memr;
    assign bus.wb_regw     = r_mwb_q.regw;
    assign bus.wb_mem2reg  = r_mwb_q.mem2reg;
    assign bus.sel         = w_sel;
    assign bus.stall       = w_stall;
    assign bus.flush       = w_flush;
    assign bus.stall_count = r_stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed checks of a forwarding controller (16-bit counter)
//               and a stall-only controller (4-bit counter) on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_NO = 7'b0000000;

    logic       clk;
    logic       rst;
    logic       pipe_en;
    logic [6:0] inst_control;
    logic [9:0] inst_alu;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       zero_flag;
    logic       mem_ready;

    int checks;
    int errors;

    pipeline_hazard_controller_if #(.REG_AW(5), .STALL_CNT_W(16)) bus_f ();
    pipeline_hazard_controller_if #(.REG_AW(5), .STALL_CNT_W(4))  bus_n ();

    assign bus_f.pipe_en      = pipe_en;
    assign bus_f.inst_control = inst_control;
    assign bus_f.inst_alu     = inst_alu;
    assign bus_f.id_rs1       = id_rs1;
    assign bus_f.id_rs2       = id_rs2;
    assign bus_f.id_rd        = id_rd;
    assign bus_f.zero_flag    = zero_flag;
    assign bus_f.mem_ready    = mem_ready;
    assign bus_n.pipe_en      = pipe_en;
    assign bus_n.inst_control = inst_control;
    assign bus_n.inst_alu     = inst_alu;
    assign bus_n.id_rs1       = id_rs1;
    assign bus_n.id_rs2       = id_rs2;
    assign bus_n.id_rd        = id_rd;
    assign bus_n.zero_flag    = zero_flag;
    assign bus_n.mem_ready    = mem_ready;

    pipeline_hazard_controller #(.REG_AW(5), .FWD_EN(1'b1), .STALL_CNT_W(16)) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    pipeline_hazard_controller #(.REG_AW(5), .FWD_EN(1'b0), .STALL_CNT_W(4)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [9:0] alu,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
        inst_control = op;
        inst_alu     = alu;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pipe_en   = 1'b0;
        zero_flag = 1'b0;
        mem_ready = 1'b0;
        set_id(OP_NO, 10'd0, 5'd0, 5'd0, 5'd0);
        step();
        rst       = 1'b0;
        pipe_en   = 1'b1;
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] vf, vn;
        do_reset();
        rst = 1'b1;
        step();
        vf = {bus_f.ex_alu_op, bus_f.ex_alu_src, bus_f.fwd_a, bus_f.fwd_b, bus_f.m_memw,
              bus_f.m_memr, bus_f.wb_regw, bus_f.wb_mem2reg, bus_f.sel, bus_f.stall, bus_f.flush};
        vn = {bus_n.ex_alu_op, bus_n.ex_alu_src, bus_n.fwd_a, bus_n.fwd_b, bus_n.m_memw,
              bus_n.m_memr, bus_n.wb_regw, bus_n.wb_mem2reg, bus_n.sel, bus_n.stall, bus_n.flush};
        checks++; if (vf !== 16'h0 || bus_f.stall_count !== 16'd0) begin errors++; $display("FAIL reset_fwd got=%h cnt=%0d exp=0", vf, bus_f.stall_count); end
        checks++; if (vn !== 16'h0 || bus_n.stall_count !== 4'd0) begin errors++; $display("FAIL reset_nofwd got=%h cnt=%0d exp=0", vn, bus_n.stall_count); end
        rst = 1'b0; pipe_en = 1'b1; mem_ready = 1'b1;
        set_id(OP_R, {7'b0000000, 3'b000}, 5'd1, 5'd2, 5'd7);
        step();
        checks++; if ({bus_f.ex_alu_op, bus_f.ex_alu_src} !== 5'b0010_0) begin errors++; $display("FAIL add_ex got=%b exp=00100", {bus_f.ex_alu_op, bus_f.ex_alu_src}); end
        set_id(OP_NO, 10'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        checks++; if ({bus_f.wb_regw, bus_f.wb_mem2reg} !== 2'b10) begin errors++; $display("FAIL add_wb got=%b exp=10", {bus_f.wb_regw, bus_f.wb_mem2reg}); end
    endtask

    task automatic test_decode();
        logic [21:0] tab [11];
        tab = '{
            {OP_R,  7'b0000000, 3'b110, 4'b0001, 1'b0},
            {OP_R,  7'b0000000, 3'b100, 4'b0011, 1'b0},
            {OP_R,  7'b0100000, 3'b000, 4'b0110, 1'b0},
            {OP_R,  7'b0000000, 3'b111, 4'b0000, 1'b0},
            {OP_R,  7'b0000001, 3'b111, 4'b0010, 1'b0},
            {OP_I,  7'b0000000, 3'b111, 4'b0000, 1'b1},
            {OP_I,  7'b0100000, 3'b000, 4'b0010, 1'b1},
            {OP_LD, 7'b0000000, 3'b010, 4'b0010, 1'b1},
            {OP_ST, 7'b0000000, 3'b010, 4'b0010, 1'b1},
            {OP_BR, 7'b0000000, 3'b000, 4'b0110, 1'b0},
            {7'b1111111, 7'b0000000, 3'b111, 4'b0000, 1'b0}
        };
        do_reset();
        for (int i = 0; i < 11; i++) begin
            logic [21:0] e;
            e = tab[i];
            set_id(e[21:15], e[14:5], 5'd1, 5'd2, 5'd3);
            step();
            checks++; if ({bus_f.ex_alu_op, bus_f.ex_alu_src} !== e[4:0]) begin errors++; $display("FAIL decode[%0d] got=%b exp=%b", i, {bus_f.ex_alu_op, bus_f.ex_alu_src}, e[4:0]); end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(OP_LD, {7'd0, 3'b010}, 5'd1, 5'd0, 5'd5);
        step();
        set_id(OP_R, {7'd0, 3'b000}, 5'd5, 5'd1, 5'd6);
        settle();
        checks++; if ({bus_f.stall, bus_f.flush} !== 2'b10) begin errors++; $display("FAIL lu_stall got=%b exp=10", {bus_f.stall, bus_f.flush}); end
        step();
        checks++; if ({bus_f.ex_alu_op, bus_f.ex_alu_src, bus_f.m_memr, bus_f.stall} !== 7'b0000_0_1_0) begin errors++; $display("FAIL lu_bubble got=%b exp=0000010", {bus_f.ex_alu_op, bus_f.ex_alu_src, bus_f.m_memr, bus_f.stall}); end
        step();
        checks++; if ({bus_f.fwd_a, bus_f.fwd_b, bus_f.ex_alu_op} !== 8'b01_00_0010) begin errors++; $display("FAIL lu_fwd_wb got=%b exp=01000010", {bus_f.fwd_a, bus_f.fwd_b, bus_f.ex_alu_op}); end
        checks++; if (bus_f.stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", bus_f.stall_count); end
    endtask

    task automatic test_fwd_m();
        do_reset();
        set_id(OP_R, {7'b0100000, 3'b000}, 5'd1, 5'd2, 5'd3);
        step();
        set_id(OP_R, {7'b0000000, 3'b111}, 5'd3, 5'd3, 5'd4);
        settle();
        checks++; if ({bus_f.stall, bus_n.stall} !== 2'b01) begin errors++; $display("FAIL raw_ex_stall got=%b exp=01", {bus_f.stall, bus_n.stall}); end
        step();
        checks++; if ({bus_f.fwd_a, bus_f.fwd_b, bus_f.ex_alu_op} !== 8'b10_10_0000) begin errors++; $display("FAIL fwd_m got=%b exp=10100000", {bus_f.fwd_a, bus_f.fwd_b, bus_f.ex_alu_op}); end
        checks++; if (bus_n.stall !== 1'b1) begin errors++; $display("FAIL raw_m_stall got=%b exp=1", bus_n.stall); end
        step();
        checks++; if ({bus_n.stall, bus_n.fwd_a} !== 3'b0_00) begin errors++; $display("FAIL raw_wb_nostall got=%b exp=000", {bus_n.stall, bus_n.fwd_a}); end
        step();
        checks++; if ({bus_n.stall_count, bus_n.fwd_a, bus_n.fwd_b} !== 8'b0010_00_00) begin errors++; $display("FAIL raw_count got=%b exp=00100000", {bus_n.stall_count, bus_n.fwd_a, bus_n.fwd_b}); end
        checks++; if (bus_f.stall_count !== 16'd0) begin errors++; $display("FAIL fwd_count got=%0d exp=0", bus_f.stall_count); end
        set_id(OP_NO, 10'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        checks++; if (bus_n.wb_regw !== 1'b1) begin errors++; $display("FAIL raw_wb_and got=%b exp=1", bus_n.wb_regw); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_id(OP_LD, {7'd0, 3'b010}, 5'd1, 5'd0, 5'd5);
        step();
        set_id(OP_BR, {7'd0, 3'b000}, 5'd1, 5'd2, 5'd0);
        step();
        set_id(OP_R, {7'd0, 3'b000}, 5'd5, 5'd1, 5'd6);
        settle();
        checks++; if ({bus_n.sel, bus_n.stall} !== 2'b01) begin errors++; $display("FAIL br_not_taken got=%b exp=01", {bus_n.sel, bus_n.stall}); end
        zero_flag = 1'b1;
        settle();
        checks++; if ({bus_f.sel, bus_f.flush, bus_f.stall} !== 3'b110) begin errors++; $display("FAIL br_fwd got=%b exp=110", {bus_f.sel, bus_f.flush, bus_f.stall}); end
        checks++; if ({bus_n.sel, bus_n.flush, bus_n.stall} !== 3'b110) begin errors++; $display("FAIL br_nofwd got=%b exp=110", {bus_n.sel, bus_n.flush, bus_n.stall}); end
        step();
        zero_flag = 1'b0;
        checks++; if ({bus_n.ex_alu_op, bus_n.ex_alu_src, bus_n.wb_regw, bus_n.wb_mem2reg} !== 7'b0000_0_11) begin errors++; $display("FAIL br_bubble got=%b exp=0000011", {bus_n.ex_alu_op, bus_n.ex_alu_src, bus_n.wb_regw, bus_n.wb_mem2reg}); end
        checks++; if (bus_n.stall_count !== 4'd0) begin errors++; $display("FAIL br_count got=%0d exp=0", bus_n.stall_count); end
    endtask

    task automatic test_mem_freeze();
        do_reset();
        set_id(OP_ST, {7'd0, 3'b010}, 5'd1, 5'd2, 5'd0);
        step();
        set_id(OP_R, {7'd0, 3'b000}, 5'd1, 5'd2, 5'd8);
        step();
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if ({bus_f.stall, bus_f.flush, bus_f.ex_alu_op, bus_f.m_memw, bus_f.wb_regw} !== 8'b1_0_0010_1_0) begin errors++; $display("FAIL freeze[%0d] got=%b exp=10001010", c, {bus_f.stall, bus_f.flush, bus_f.ex_alu_op, bus_f.m_memw, bus_f.wb_regw}); end
            step();
        end
        checks++; if (bus_f.stall_count !== 16'd3) begin errors++; $display("FAIL freeze_count got=%0d exp=3", bus_f.stall_count); end
        mem_ready = 1'b1;
        settle();
        checks++; if (bus_f.stall !== 1'b0) begin errors++; $display("FAIL freeze_release got=%b exp=0", bus_f.stall); end
        step();
        checks++; if ({bus_f.m_memw, bus_f.wb_regw, bus_f.ex_alu_op} !== 6'b0_0_0010) begin errors++; $display("FAIL freeze_advance got=%b exp=000010", {bus_f.m_memw, bus_f.wb_regw, bus_f.ex_alu_op}); end
        pipe_en = 1'b0;
        settle();
        checks++; if (bus_f.stall !== 1'b1) begin errors++; $display("FAIL pipe_en_stall got=%b exp=1", bus_f.stall); end
        pipe_en = 1'b1;
    endtask

    task automatic test_saturate();
        logic [15:0] vf, vn;
        do_reset();
        set_id(OP_LD, {7'd0, 3'b010}, 5'd1, 5'd0, 5'd5);
        step();
        set_id(OP_R, {7'd0, 3'b000}, 5'd1, 5'd2, 5'd9);
        step();
        mem_ready = 1'b0;
        repeat (18) step();
        checks++; if (bus_n.stall_count !== 4'hF) begin errors++; $display("FAIL sat_count got=%0d exp=15", bus_n.stall_count); end
        checks++; if (bus_f.stall_count !== 16'd18) begin errors++; $display("FAIL wide_count got=%0d exp=18", bus_f.stall_count); end
        checks++; if ({bus_f.m_memr, bus_f.ex_alu_op} !== 5'b1_0010) begin errors++; $display("FAIL sat_hold got=%b exp=10010", {bus_f.m_memr, bus_f.ex_alu_op}); end
        rst = 1'b1;
        step();
        vf = {bus_f.ex_alu_op, bus_f.ex_alu_src, bus_f.fwd_a, bus_f.fwd_b, bus_f.m_memw,
              bus_f.m_memr, bus_f.wb_regw, bus_f.wb_mem2reg, bus_f.sel, bus_f.stall, bus_f.flush};
        vn = {bus_n.ex_alu_op, bus_n.ex_alu_src, bus_n.fwd_a, bus_n.fwd_b, bus_n.m_memw,
              bus_n.m_memr, bus_n.wb_regw, bus_n.wb_mem2reg, bus_n.sel, bus_n.stall, bus_n.flush};
        checks++; if (vf !== 16'h0 || bus_f.stall_count !== 16'd0) begin errors++; $display("FAIL midreset_fwd got=%h cnt=%0d exp=0", vf, bus_f.stall_count); end
        checks++; if (vn !== 16'h0 || bus_n.stall_count !== 4'd0) begin errors++; $display("FAIL midreset_nofwd got=%h cnt=%0d exp=0", vn, bus_n.stall_count); end
        rst = 1'b0;
        mem_ready = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; pipe_en = 1'b0; zero_flag = 1'b0; mem_ready = 1'b0;
        set_id(OP_NO, 10'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_decode();
        test_load_use();
        test_fwd_m();
        test_branch_flush();
        test_mem_freeze();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
